// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline register addresses and enables in,
// stall/flush/forward controls and watchdog/perf status out.
interface hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  rs1D;
    logic [RA_W-1:0]  rs2D;
    logic [RA_W-1:0]  rs1E;
    logic [RA_W-1:0]  rs2E;
    logic [RA_W-1:0]  rdE;
    logic [RA_W-1:0]  rdM;
    logic [RA_W-1:0]  rdW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             regWriteM;
    logic             regWriteW;
    logic             memReqM;
    logic             dmem_ready;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output ResultSrcE, PCSrcE, regWriteM, regWriteW,
        output memReqM, dmem_ready,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW,
        input  forwardAE, forwardBE,
        input  mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  ResultSrcE, PCSrcE, regWriteM, regWriteW,
        input  memReqM, dmem_ready,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW,
        output forwardAE, forwardBE,
        output mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use and branch
// hazards, data-memory wait sequencing with watchdog, perf counters.
module hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input logic        CLK,
    input logic        reset,
    hazard_ctrl_if.slave hz
);
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [RA_W-1:0]  R0   = '0;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [WC_W-1:0]  WMAX = WC_W'(MAX_WAIT);

    typedef enum logic {RUN, WAIT} state_t;

    state_t           state, state_n;
    logic [WC_W-1:0]  wait_cnt, wait_n;
    logic             tmo_q, tmo_set;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             mem_busy, rel, mem_stall, lw_stall;

    assign mem_busy  = hz.memReqM & ~hz.dmem_ready;
    assign rel       = (state == WAIT) && (wait_cnt == WMAX);
    assign mem_stall = mem_busy & ~rel;
    assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.rdE != R0) &&
                       ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            if (tmo_set) tmo_q <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        tmo_set = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_busy) begin
                    state_n = WAIT;
                    wait_n  = WC_W'(1);
                end
            end
            WAIT: begin
                if (hz.dmem_ready || !hz.memReqM) begin
                    state_n = RUN;
                    wait_n  = '0;
                end else if (rel) begin
                    state_n = RUN;
                    wait_n  = '0;
                    tmo_set = 1'b1;
                end else begin
                    wait_n = wait_cnt + WC_W'(1);
                end
            end
            default: begin
                state_n = RUN;
                wait_n  = '0;
            end
        endcase
    end

    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushW    = 1'b0;
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        if (!reset) begin
            if (hz.regWriteM && hz.rdM != R0 && hz.rdM == hz.rs1E)
                hz.forwardAE = 2'b10;
            else if (hz.regWriteW && hz.rdW != R0 && hz.rdW == hz.rs1E)
                hz.forwardAE = 2'b01;
            if (hz.regWriteM && hz.rdM != R0 && hz.rdM == hz.rs2E)
                hz.forwardBE = 2'b10;
            else if (hz.regWriteW && hz.rdW != R0 && hz.rdW == hz.rs2E)
                hz.forwardBE = 2'b01;
        end
        // Overlapping conditions: first true item wins.
        priority case (1'b1)
            reset: begin
                hz.flushD = 1'b1;
                hz.flushE = 1'b1;
                hz.flushW = 1'b1;
            end
            mem_stall: begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.stallM = 1'b1;
                hz.flushW = 1'b1;
            end
            hz.PCSrcE: begin
                hz.flushD = 1'b1;
                hz.flushE = 1'b1;
            end
            lw_stall: begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.flushE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hz.stallF && stall_q != CMAX) stall_q <= stall_q + CNT_W'(1);
            if (hz.flushE && flush_q != CMAX) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.mem_timeout = tmo_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush,
// memory wait, watchdog release, reset mid-wait and counter saturation.
module tb_hazard_ctrl;
    localparam int RA_W     = 5;
    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();

    hazard_ctrl #(
        .RA_W(RA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .CLK(clk), .reset(reset), .hz(hz)
    );

    always #5 clk = ~clk;

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    wire [6:0] ctl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                      hz.flushD, hz.flushE, hz.flushW};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
        hz.rdE = '0; hz.rdM = '0; hz.rdW = '0;
        hz.ResultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
        hz.memReqM = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Counts consecutive stallF cycles, stopping on the first non-stall
    // cycle without clocking it; done=0 if the bound expired.
    task automatic count_stalls(output int n, output bit done);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (hz.stallF) begin
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b1;
        hz.memReqM = 1'b1; hz.PCSrcE = 1'b1;
        hz.regWriteM = 1'b1; hz.rdM = 5'd5; hz.rs1E = 5'd5;
        #1;
        n_run++;
        if (ctl !== 7'b0000111) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 0000111", ctl);
        end
        n_run++;
        if (hz.forwardAE !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_fwd got %b want 00", hz.forwardAE);
        end
        tick();
        n_run++;
        if ({hz.stall_cnt, hz.flush_cnt, hz.mem_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs got %0d %0d %b want 0 0 0",
                     hz.stall_cnt, hz.flush_cnt, hz.mem_timeout);
        end
        reset = 1'b0;
        clear_in();
    endtask

    task automatic test_forward();
        clear_in();
        hz.rdM = 5'd5; hz.regWriteM = 1'b1; hz.rs1E = 5'd5;
        hz.rdW = 5'd5; hz.regWriteW = 1'b1;
        #1;
        n_run++;
        if (hz.forwardAE !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_mem_wins got %b want 10", hz.forwardAE);
        end
        hz.rdM = 5'd0;
        #1;
        n_run++;
        if (hz.forwardAE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_rdM0 got %b want 01", hz.forwardAE);
        end
        hz.regWriteW = 1'b0;
        #1;
        n_run++;
        if (hz.forwardAE !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_none got %b want 00", hz.forwardAE);
        end
        hz.rs1E = 5'd9; hz.rs2E = 5'd3;
        hz.rdM = 5'd3; hz.regWriteM = 1'b1;
        hz.rdW = 5'd3; hz.regWriteW = 1'b1;
        #1;
        n_run++;
        if ({hz.forwardAE, hz.forwardBE} !== 4'b0010) begin
            n_fail++;
            $display("FAIL fwdB_mem got %b%b want 0010",
                     hz.forwardAE, hz.forwardBE);
        end
        hz.rdM = 5'd4;
        #1;
        n_run++;
        if (hz.forwardBE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwdB_wb got %b want 01", hz.forwardBE);
        end
        clear_in();
    endtask

    task automatic test_lw_stall();
        do_reset();
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
        #1;
        n_run++;
        if (ctl !== 7'b1100010) begin
            n_fail++;
            $display("FAIL lw_ctl got %b want 1100010", ctl);
        end
        tick();
        clear_in();
        #1;
        n_run++;
        if (ctl !== 7'b0000000) begin
            n_fail++;
            $display("FAIL lw_after got %b want 0000000", ctl);
        end
        n_run++;
        if ({hz.stall_cnt, hz.flush_cnt} !== {5'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL lw_cnt got %0d %0d want 1 1",
                     hz.stall_cnt, hz.flush_cnt);
        end
        hz.ResultSrcE = 2'b01;
        #1;
        n_run++;
        if (ctl !== 7'b0000000) begin
            n_fail++;
            $display("FAIL lw_rd0 got %b want 0000000", ctl);
        end
        hz.ResultSrcE = 2'b10; hz.rdE = 5'd7; hz.rs1D = 5'd7;
        #1;
        n_run++;
        if (ctl !== 7'b0000000) begin
            n_fail++;
            $display("FAIL lw_notload got %b want 0000000", ctl);
        end
        clear_in();
    endtask

    task automatic test_branch();
        do_reset();
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd7; hz.rs1D = 5'd7;
        hz.PCSrcE = 1'b1;
        #1;
        n_run++;
        if (ctl !== 7'b0000110) begin
            n_fail++;
            $display("FAIL br_ctl got %b want 0000110", ctl);
        end
        tick();
        clear_in();
        #1;
        n_run++;
        if ({hz.stall_cnt, hz.flush_cnt} !== {5'd0, 5'd1}) begin
            n_fail++;
            $display("FAIL br_cnt got %0d %0d want 0 1",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hz.memReqM = 1'b1; hz.PCSrcE = 1'b1;
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd7; hz.rs1D = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_run++;
            if (ctl !== 7'b1111001) begin
                n_fail++;
                $display("FAIL mw_stall%0d got %b want 1111001", i, ctl);
            end
            tick();
        end
        hz.dmem_ready = 1'b1; hz.PCSrcE = 1'b0; hz.ResultSrcE = 2'b00;
        #1;
        n_run++;
        if (ctl !== 7'b0000000) begin
            n_fail++;
            $display("FAIL mw_ready got %b want 0000000", ctl);
        end
        tick();
        clear_in();
        #1;
        n_run++;
        if ({hz.stall_cnt, hz.flush_cnt, hz.mem_timeout}
            !== {5'd3, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mw_cnt got %0d %0d %b want 3 0 0",
                     hz.stall_cnt, hz.flush_cnt, hz.mem_timeout);
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  done;
        hz.memReqM = 1'b1; hz.dmem_ready = 1'b0;
        count_stalls(n, done);
        n_run++;
        if (!done || n != 16) begin
            n_fail++;
            $display("FAIL to_len got %0d done=%b want 16", n, done);
        end
        n_run++;
        if ({ctl, hz.mem_timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL to_release got %b %b want 0000000 0",
                     ctl, hz.mem_timeout);
        end
        tick();
        hz.memReqM = 1'b0;
        #1;
        n_run++;
        if ({hz.mem_timeout, hz.stall_cnt} !== {1'b1, 5'd19}) begin
            n_fail++;
            $display("FAIL to_flag got %b %0d want 1 19",
                     hz.mem_timeout, hz.stall_cnt);
        end
        repeat (3) tick();
        n_run++;
        if (hz.mem_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky got %b want 1", hz.mem_timeout);
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        bit done;
        hz.memReqM = 1'b1; hz.dmem_ready = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_run++;
        if ({hz.stall_cnt, hz.flush_cnt, hz.mem_timeout} !== '0) begin
            n_fail++;
            $display("FAIL rw_regs got %0d %0d %b want 0 0 0",
                     hz.stall_cnt, hz.flush_cnt, hz.mem_timeout);
        end
        count_stalls(n, done);
        n_run++;
        if (!done || n != 16) begin
            n_fail++;
            $display("FAIL rw_len got %0d done=%b want 16", n, done);
        end
        tick();
        clear_in();
    endtask

    task automatic test_wait_drop();
        int n;
        bit done;
        do_reset();
        hz.memReqM = 1'b1;
        repeat (5) tick();
        hz.memReqM = 1'b0;
        #1;
        n_run++;
        if (ctl !== 7'b0000000) begin
            n_fail++;
            $display("FAIL wd_drop got %b want 0000000", ctl);
        end
        tick();
        hz.memReqM = 1'b1;
        count_stalls(n, done);
        n_run++;
        if (!done || n != 16) begin
            n_fail++;
            $display("FAIL wd_len got %0d done=%b want 16", n, done);
        end
        n_run++;
        if (hz.mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_tmo got %b want 0", hz.mem_timeout);
        end
        tick();
        clear_in();
    endtask

    task automatic test_saturate();
        do_reset();
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd2; hz.rs1D = 5'd2;
        repeat (40) tick();
        clear_in();
        #1;
        n_run++;
        if ({hz.stall_cnt, hz.flush_cnt} !== {5'd31, 5'd31}) begin
            n_fail++;
            $display("FAIL sat_cnt got %0d %0d want 31 31",
                     hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    initial begin
        clear_in();
        test_reset();
        test_forward();
        test_lw_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        test_wait_drop();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
